// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with a maskable level interrupt.
// Registers: CTRL (EN/MODE/IM), PRESET (r/w), COUNT (ro), reserved.
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t           state_r, state_nx;
  logic             ctrl_en_r;
  logic [1:0]       ctrl_mode_r;
  logic             ctrl_im_r;
  logic [CNT_W-1:0] preset_r;
  logic [CNT_W-1:0] count_r, count_nx;
  logic             irq_flag_r;

  logic wr_ok_s, wr_ctrl_s, wr_preset_s;
  logic en_clear_s, flag_set_s, flag_clr_fsm_s;
  logic unused_s;

  // Only full-word writes are honoured; sub-word accesses fault in the CPU.
  assign wr_ok_s     = sel & we & (byteen == 4'b1111);
  assign wr_ctrl_s   = wr_ok_s & (addr[3:2] == 2'd0);
  assign wr_preset_s = wr_ok_s & (addr[3:2] == 2'd1);
  assign unused_s    = ^{addr[31:4], addr[1:0]};

  // Next-state and count update for the timer sequence
  always_comb begin
    state_nx       = state_r;
    count_nx       = count_r;
    en_clear_s     = 1'b0;
    flag_set_s     = 1'b0;
    flag_clr_fsm_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ctrl_en_r) state_nx = LOAD;
        else           state_nx = IDLE;
      end
      LOAD: begin
        count_nx = preset_r;
        state_nx = CNT;
      end
      CNT: begin
        if (!ctrl_en_r) begin
          state_nx = IDLE;
        end else if (count_r <= CNT_W'(1)) begin
          // PRESET=0 lands here immediately, so it behaves like PRESET=1.
          count_nx   = '0;
          flag_set_s = 1'b1;
          state_nx   = INT;
        end else begin
          count_nx = count_r - CNT_W'(1);
        end
      end
      INT: begin
        if (ctrl_mode_r == 2'b01) begin
          flag_clr_fsm_s = 1'b1;
          state_nx       = LOAD;
        end else begin
          en_clear_s = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, register file and interrupt flag; bus writes override the FSM's EN clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ctrl_en_r   <= 1'b0;
      ctrl_mode_r <= 2'b00;
      ctrl_im_r   <= 1'b0;
      preset_r    <= '0;
      count_r     <= '0;
      irq_flag_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      count_r <= count_nx;
      if (wr_ctrl_s) begin
        ctrl_en_r   <= wdata[0];
        ctrl_mode_r <= wdata[2:1];
        ctrl_im_r   <= wdata[3];
      end else if (en_clear_s) begin
        ctrl_en_r <= 1'b0;
      end
      if (wr_preset_s) begin
        preset_r <= CNT_W'(wdata);
      end
      if (flag_set_s) begin
        irq_flag_r <= 1'b1;
      end else if (wr_ctrl_s | wr_preset_s | flag_clr_fsm_s) begin
        irq_flag_r <= 1'b0;
      end
    end
  end

  // Read mux, independent of sel and we
  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      2'd0:    rdata = {28'd0, ctrl_im_r, ctrl_mode_r, ctrl_en_r};
      2'd1:    rdata = 32'(preset_r);
      2'd2:    rdata = 32'(count_r);
      2'd3:    rdata = 32'd0;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = irq_flag_r & ctrl_im_r;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed test-plan steps followed by
// randomized bus traffic, all compared against a behavioural timer model.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset, sel, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  byteen;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase is one of "idle", "load", "count", "fire".
  bit          m_en;
  bit [1:0]    m_mode;
  bit          m_im;
  int unsigned m_preset, m_count;
  string       m_phase;
  bit          m_flag;

  timer_counter #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we),
    .byteen(byteen), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_en = 1'b0; m_mode = 2'd0; m_im = 1'b0;
    m_preset = 0; m_count = 0; m_phase = "idle"; m_flag = 1'b0;
  endfunction

  // One clock edge of the timer rules, applied to the pre-edge values.
  function automatic void model_step(bit rst, bit s, bit [1:0] off, bit w,
                                     bit [3:0] be, bit [31:0] d);
    bit          acc = s && w && (be == 4'hF);
    bit          n_en = m_en;
    string       n_phase = m_phase;
    int unsigned n_count = m_count;
    bit          fire = 1'b0;
    bit          drop = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_phase == "idle") begin
      if (m_en) n_phase = "load";
    end else if (m_phase == "load") begin
      n_count = m_preset;
      n_phase = "count";
    end else if (m_phase == "count") begin
      if (!m_en) n_phase = "idle";
      else if (m_count <= 1) begin
        n_count = 0; fire = 1'b1; n_phase = "fire";
      end else n_count = m_count - 1;
    end else begin
      if (m_mode == 2'd1) begin
        drop = 1'b1; n_phase = "load";
      end else begin
        n_en = 1'b0; n_phase = "idle";
      end
    end
    if (acc && off == 2'd0) begin
      n_en = d[0]; m_mode = d[2:1]; m_im = d[3]; drop = 1'b1;
    end
    if (acc && off == 2'd1) begin
      m_preset = d; drop = 1'b1;
    end
    if (fire) m_flag = 1'b1;
    else if (drop) m_flag = 1'b0;
    m_en = n_en; m_phase = n_phase; m_count = n_count;
  endfunction

  function automatic logic [31:0] model_read(int off);
    case (off)
      0:       return {28'd0, m_im, m_mode, m_en};
      1:       return m_preset;
      2:       return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put_addr(input int off);
    addr = $urandom();
    addr[3:2] = off[1:0];
  endtask

  // Drive one bus cycle, clock it, then compare irq and all four registers.
  task automatic cycle(input bit rst, input bit s, input bit [1:0] off, input bit w,
                       input bit [3:0] be, input bit [31:0] d);
    reset = rst; sel = s; we = w; byteen = be; wdata = d;
    put_addr(int'(off));
    @(posedge clk);
    model_step(rst, s, off, w, be, d);
    #1;
    reset = 1'b0; sel = 1'b0; we = 1'b0;
    chk("irq", {31'd0, irq}, {31'd0, m_flag & m_im});
    for (int i = 0; i < 4; i++) begin
      put_addr(i);
      #1;
      chk($sformatf("reg%0d", i), rdata, model_read(i));
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 32'd0);
  endtask

  task automatic wr(input bit [1:0] off, input bit [31:0] d);
    cycle(1'b0, 1'b1, off, 1'b1, 4'hF, d);
  endtask

  // Fixed-value check of one register, made between edges.
  task automatic peek(input int off, input logic [31:0] exp, input string tag);
    put_addr(off);
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    int r;
    bit [31:0] d;
    reset = 1'b1; sel = 1'b0; we = 1'b0; byteen = 4'h0; wdata = 32'd0; addr = 32'd0;
    model_reset();

    // 1: reset
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 32'd0);
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 32'd0);
    idle();
    peek(0, 32'd0, "t1_ctrl"); peek(1, 32'd0, "t1_preset"); peek(2, 32'd0, "t1_count");
    chk("t1_irq", {31'd0, irq}, 32'd0);

    // 2: one-shot, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);                        // E0
    idle();                                 // E1
    idle(); peek(2, 32'd3, "t2_cnt_e2");
    idle(); peek(2, 32'd2, "t2_cnt_e3");
    idle(); peek(2, 32'd1, "t2_cnt_e4");
    idle(); peek(2, 32'd0, "t2_cnt_e5"); chk("t2_irq_e5", {31'd0, irq}, 32'd1);
    idle(); peek(0, 32'h8, "t2_ctrl_e6"); chk("t2_irq_e6", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h8); chk("t2_irq_clr", {31'd0, irq}, 32'd0);

    // 3: auto-reload, PRESET=2, irq every 4 cycles
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);                        // E0
    for (int k = 1; k <= 12; k++) begin
      idle();
      chk($sformatf("t3_irq_e%0d", k), {31'd0, irq}, {31'd0, (k % 4) == 0});
    end
    wr(2'd0, 32'h3);
    for (int k = 0; k < 8; k++) begin
      idle();
      chk("t3_masked", {31'd0, irq}, 32'd0);
    end
    wr(2'd0, 32'h0);
    repeat (4) idle();

    // 4: stop mid-count, COUNT freezes at 7
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);                        // E0
    repeat (4) idle();                      // E1..E4, COUNT=8
    wr(2'd0, 32'h8); peek(2, 32'd7, "t4_cnt_stop");
    idle(); peek(2, 32'd7, "t4_cnt_frozen");
    wr(2'd1, 32'd20); peek(2, 32'd7, "t4_cnt_after_preset");
    idle(); peek(2, 32'd7, "t4_cnt_hold");
    wr(2'd0, 32'h9);
    idle();
    idle(); peek(2, 32'd20, "t4_reload");
    wr(2'd0, 32'h8);
    repeat (3) idle(); peek(2, 32'd19, "t4_cnt_19");

    // 5: ignored writes
    cycle(1'b0, 1'b1, 2'd2, 1'b1, 4'hF, 32'hFFFF); peek(2, 32'd19, "t5_cnt_ro");
    cycle(1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 32'h9); peek(0, 32'h8, "t5_partial");
    cycle(1'b0, 1'b0, 2'd0, 1'b1, 4'hF, 32'h9);    peek(0, 32'h8, "t5_nosel");
    cycle(1'b0, 1'b1, 2'd3, 1'b1, 4'hF, 32'h5A5A); peek(3, 32'd0, "t5_rsvd");

    // 6: PRESET=0, then reset mid-count
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);                        // E0
    idle();
    idle(); chk("t6_irq_e2", {31'd0, irq}, 32'd0);
    idle(); chk("t6_irq_e3", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h9);
    repeat (3) idle(); peek(2, 32'd49, "t6_cnt_49");
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 32'd0);
    peek(0, 32'd0, "t6_rst_ctrl"); peek(1, 32'd0, "t6_rst_preset"); peek(2, 32'd0, "t6_rst_cnt");
    chk("t6_rst_irq", {31'd0, irq}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        d = $urandom();
        d[0] = ($urandom_range(0, 9) < 7);
        wr(2'd0, d);
      end else if (r < 14) begin
        wr(2'd1, $urandom_range(0, 6));
      end else if (r < 22) begin
        d = $urandom();
        cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1,
              4'($urandom_range(0, 15)), d);
      end else if (r < 23) begin
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 32'd0);
      end else begin
        idle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped timer that acts as a bus responder on the CPU data port, behind the system bridge.
- Two instances are used: TC0 at 0x7f00–0x7f0b and TC1 at 0x7f10–0x7f1b.
- The CPU drives address, write data and byte enables, and reads back register contents.
- The block counts down a preset value and raises an interrupt line that feeds the CPU's TC0_int/TC1_int inputs.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- sel  in  1  bridge address decode hit for this instance
- addr  in  32  byte address; only addr[3:2] is decoded
- we  in  1  write request (CPU MemWrite in the M stage)
- byteen  in  4  byte enables from CPU
- wdata  in  32  write data
- rdata  out  32  read data, combinational
- irq  out  1  interrupt request, registered, level

Behaviour:
- Register map by addr[3:2]:
  - 0: CTRL. bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] read as 0.
  - 1: PRESET, read/write.
  - 2: COUNT, read-only.
  - 3: reserved, reads 0.
- Write condition: sel & we & byteen==4'b1111.
  - Partial byteen is ignored; the CPU faults sub-word timer accesses, so ignoring is sufficient.
  - Writes to offset 2 or 3 are ignored. No error is signalled.
- rdata = register selected by addr[3:2]. It does not depend on sel or we.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0, rdata reflects zeros.
- irq = irq_flag & CTRL.IM, registered: both terms are flops, with an AND on the output.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN -> LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT:
    - If !EN -> IDLE, COUNT holds.
    - Else if COUNT <= 1: COUNT <= 0, irq_flag <= 1, -> INT.
    - Else COUNT <= COUNT-1.
  - INT, MODE==00 (one-shot): CTRL.EN <= 0; -> IDLE; irq_flag stays 1.
  - INT, MODE==01 (auto-reload): irq_flag <= 0; -> LOAD. The irq pulse is exactly 1 cycle.
  - INT, MODE 10/11: behave as 00.
- irq_flag is cleared by any accepted write to CTRL or PRESET. It is also cleared in INT when MODE==01.
- Latency:
  - With EN written at edge E0, COUNT=PRESET after E2.
  - irq rises after edge E2+max(PRESET,1)-1+1.
  - Example: PRESET=3 gives irq high after E5.
- PRESET=0 behaves as PRESET=1: CNT sees COUNT=0, goes straight to INT.
- Simultaneous events:
  - An accepted CTRL write at the same edge as an FSM-driven EN clear in INT: the bus write wins for CTRL. The FSM state transition still occurs.
  - A PRESET write during CNT updates PRESET only. COUNT is unaffected until the next LOAD.
  - A CTRL write with EN=0 during CNT: the next edge takes CNT -> IDLE with COUNT frozen at its current value.
  - A write that clears irq_flag at the same edge CNT sets it: the set wins.
- Reset asserted mid-count returns everything to reset values at that edge, regardless of state.
- No wrap-around: COUNT never decrements below 0.

Test Plan:
1. Reset for 2 cycles, then read offsets 0/1/2/3 -> rdata=0 each; irq=0.
2. Write PRESET=3, then at E0 write CTRL=0x9 (EN, mode 0, IM).
   - Required: COUNT reads 3, 2, 1, 0 after E2, E3, E4, E5; irq=1 after E5.
   - After E6: CTRL reads 0x8 and state is IDLE; irq stays 1 until a CTRL write of 0x8 clears it the next cycle.
3. PRESET=2, CTRL=0xB (EN, mode 1, IM).
   - Required: irq pulses 1 cycle high, periodically every 4 cycles (LOAD, CNT×2, INT).
   - Clearing IM (CTRL=0x3) keeps counting with irq=0.
4. Mid-count: PRESET=10, start, then after 3 decrements write CTRL=0x8.
   - Required: next edge gives IDLE, COUNT frozen at 7.
   - Writing PRESET=20 then leaves COUNT at 7; re-enabling reloads 20.
5. Illegal writes:
   - Write to offset 2 with 0xFFFF -> COUNT unchanged.
   - Write to CTRL with byteen=4'b0001 -> CTRL unchanged.
   - Write with sel=0 -> ignored.
6. PRESET=0 with EN+IM -> irq high 3 edges after the enabling write. Assert reset while in CNT with PRESET=50 -> all registers 0 and irq 0 after that edge.
